// File: rtl/voltmeter_pkg.sv
// voltmeter_pkg: types and constants shared by the voltmeter measurement path.
`default_nettype none

package voltmeter_pkg;

    localparam int MEAS_COUNT_W          = 12;
    localparam int DEFAULT_SETTLE_CYCLES = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } meas_state_t;

endpackage

`default_nettype wire

// File: rtl/comp_synchronizer.sv
// comp_synchronizer: comparator metastability chain; optional 3-sample majority
// filter when COMP_FILTER_EN is defined.
`default_nettype none

module comp_synchronizer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic comp_i,
    output logic comp_sync_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], comp_i};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef COMP_FILTER_EN
    logic [1:0] hist_q;
    logic       filt_q;

    // Majority of the current and two previous samples, registered: a lone
    // one-cycle pulse never wins the vote.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hist_q <= '0;
            filt_q <= 1'b0;
        end else begin
            hist_q <= {hist_q[0], sync_out};
            filt_q <= (sync_out & hist_q[0]) | (sync_out & hist_q[1]) | (hist_q[0] & hist_q[1]);
        end
    end

    assign comp_sync_o = filt_q;
`else
    assign comp_sync_o = sync_out;
`endif

endmodule

`default_nettype wire

// File: rtl/measurement_window_ctrl.sv
// measurement_window_ctrl: settle-then-measure window sequencer feeding the
// voltmeter ones-density counter. Optional build macro: COMP_FILTER_EN.
`default_nettype none

module measurement_window_ctrl
    import voltmeter_pkg::*;
#(
    parameter int WINDOW_W      = MEAS_COUNT_W,
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic                continuous_i,
    input  logic [WINDOW_W-1:0] window_len_i,
    input  logic                comp_i,
    output logic                count_clear_o,
    output logic                window_open_o,
    output logic                measurement_en_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam logic [7:0]          SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [WINDOW_W-1:0] WIN_ONE     = WINDOW_W'(1);

    meas_state_t         state_q, state_d;
    logic [WINDOW_W-1:0] win_len_q, win_len_d;
    logic [WINDOW_W-1:0] win_cnt_q, win_cnt_d;
    logic [7:0]          settle_cnt_q, settle_cnt_d;
    logic                load;
    logic                comp_sync;
    logic                count_clear_q, window_open_q, busy_q, done_q;

    comp_synchronizer #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_comp_sync (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .comp_i      (comp_i),
        .comp_sync_o (comp_sync)
    );

    always_comb begin
        state_d      = state_q;
        win_len_d    = win_len_q;
        win_cnt_d    = win_cnt_q;
        settle_cnt_d = settle_cnt_q;
        load         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i && !abort_i) begin
                    load = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (settle_cnt_q == 8'd0) begin
                    if (win_len_q != '0) begin
                        state_d   = ST_MEASURE;
                        win_cnt_d = win_len_q - WIN_ONE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    settle_cnt_d = settle_cnt_q - 8'd1;
                end
            end
            ST_MEASURE: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (win_cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    win_cnt_d = win_cnt_q - WIN_ONE;
                end
            end
            ST_DONE: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (continuous_i) begin
                    load = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        // Fresh start and continuous restart share the same reload.
        if (load) begin
            state_d      = ST_SETTLE;
            win_len_d    = window_len_i;
            settle_cnt_d = SETTLE_LOAD;
        end
    end

    // Outputs are decoded from the next state and registered, so every output
    // is glitch-free and aligned with the state it describes.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= ST_IDLE;
            win_len_q     <= '0;
            win_cnt_q     <= '0;
            settle_cnt_q  <= 8'd0;
            count_clear_q <= 1'b0;
            window_open_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            win_len_q     <= win_len_d;
            win_cnt_q     <= win_cnt_d;
            settle_cnt_q  <= settle_cnt_d;
            count_clear_q <= load;
            window_open_q <= (state_d == ST_MEASURE);
            busy_q        <= (state_d != ST_IDLE);
            done_q        <= (state_d == ST_DONE);
        end
    end

    assign count_clear_o    = count_clear_q;
    assign window_open_o    = window_open_q;
    assign measurement_en_o = window_open_q & comp_sync;
    assign busy_o           = busy_q;
    assign done_o           = done_q;

endmodule

`default_nettype wire

// File: tb/tb_measurement_window_ctrl.sv
// tb_measurement_window_ctrl: directed scenarios plus randomized run against a
// schedule-based reference model of the measurement sequencer.
`default_nettype none

module tb_measurement_window_ctrl;

    localparam int S     = 16;
    localparam int SYNC  = 2;
    localparam int TRN   = 1400;
    localparam int NRAND = 4000;
    localparam int B_CLR = 0, B_WIN = 1, B_EN = 2, B_BUSY = 3, B_DONE = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, abort = 1'b0, cont = 1'b0, comp = 1'b0;
    logic [11:0] wlen = '0;
    logic        clr_o, win_o, en_o, busy_o, done_o;

    int total = 0;
    int bad   = 0;

    bit          in_start [TRN];
    bit          in_abort [TRN];
    bit          in_cont  [TRN];
    bit          in_comp  [TRN];
    logic [11:0] in_len   [TRN];
    logic [4:0]  tr       [TRN];
    bit          chist    [NRAND];

    measurement_window_ctrl #(
        .WINDOW_W      (12),
        .SETTLE_CYCLES (S),
        .SYNC_STAGES   (SYNC)
    ) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .start_i          (start),
        .abort_i          (abort),
        .continuous_i     (cont),
        .window_len_i     (wlen),
        .comp_i           (comp),
        .count_clear_o    (clr_o),
        .window_open_o    (win_o),
        .measurement_en_o (en_o),
        .busy_o           (busy_o),
        .done_o           (done_o)
    );

    always #5 clk = ~clk;

    task automatic clear_stim();
        for (int i = 0; i < TRN; i++) begin
            in_start[i] = 0; in_abort[i] = 0; in_cont[i] = 0; in_comp[i] = 0; in_len[i] = '0;
        end
    endtask

    // Cycle i: record outputs at the negedge, then drive the cycle-i inputs.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tr[i] = {done_o, busy_o, en_o, win_o, clr_o};
            start = in_start[i]; abort = in_abort[i]; cont = in_cont[i];
            comp  = in_comp[i];  wlen  = in_len[i];
        end
    endtask

    function automatic int cnt(input int b, input int n);
        int c = 0;
        for (int i = 0; i < n; i++) c += int'(tr[i][b]);
        return c;
    endfunction

    function automatic int nth(input int b, input int n, input int which);
        int seen = 0;
        for (int i = 0; i < n; i++) begin
            if (tr[i][b]) begin
                if (seen == which) return i;
                seen++;
            end
        end
        return -1;
    endfunction

    function automatic int lastb(input int b, input int n);
        int l = -1;
        for (int i = 0; i < n; i++) if (tr[i][b]) l = i;
        return l;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if ({clr_o, win_o, en_o, busy_o, done_o} !== 5'b0) begin bad++; $display("FAIL reset_outputs: got %b want 00000", {clr_o, win_o, en_o, busy_o, done_o}); end
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_idle_busy: got %b want 0", busy_o); end
    endtask

    task automatic test_basic();
        clear_stim();
        in_start[0] = 1;
        for (int i = 0; i < 130; i++) begin in_comp[i] = 1; in_len[i] = (i == 0) ? 12'd100 : 12'd7; end
        run(130);
        total++; if (tr[1][B_CLR] !== 1'b1) begin bad++; $display("FAIL basic_clear_at_1: got %b want 1", tr[1][B_CLR]); end
        total++; if (cnt(B_CLR, 130) != 1) begin bad++; $display("FAIL basic_clear_count: got %0d want 1", cnt(B_CLR, 130)); end
        total++; if (nth(B_WIN, 130, 0) != S + 1) begin bad++; $display("FAIL basic_win_first: got %0d want %0d", nth(B_WIN, 130, 0), S + 1); end
        total++; if (cnt(B_WIN, 130) != 100) begin bad++; $display("FAIL basic_win_len: got %0d want 100", cnt(B_WIN, 130)); end
        total++; if (lastb(B_WIN, 130) != S + 100) begin bad++; $display("FAIL basic_win_last: got %0d want %0d", lastb(B_WIN, 130), S + 100); end
        total++; if (cnt(B_EN, 130) != 100) begin bad++; $display("FAIL basic_counter: got %0d want 100", cnt(B_EN, 130)); end
        total++; if (nth(B_DONE, 130, 0) != S + 101 || cnt(B_DONE, 130) != 1) begin bad++; $display("FAIL basic_done: got idx %0d n %0d want idx %0d n 1", nth(B_DONE, 130, 0), cnt(B_DONE, 130), S + 101); end
        total++; if (tr[S + 101][B_BUSY] !== 1'b1 || tr[S + 102][B_BUSY] !== 1'b0) begin bad++; $display("FAIL basic_busy_end: got %b%b want 10", tr[S + 101][B_BUSY], tr[S + 102][B_BUSY]); end
    endtask

    task automatic test_duty();
        int d;
        clear_stim();
        in_start[0] = 1;
        for (int i = 0; i < 1030; i++) begin in_comp[i] = bit'(i % 2); in_len[i] = 12'd1000; end
        run(1030);
        d = S + 1001;
        total++; if (cnt(B_EN, 1030) < 499 || cnt(B_EN, 1030) > 501) begin bad++; $display("FAIL duty_count: got %0d want 500+-1", cnt(B_EN, 1030)); end
        total++; if (cnt(B_WIN, 1030) != 1000) begin bad++; $display("FAIL duty_win_len: got %0d want 1000", cnt(B_WIN, 1030)); end
        total++; if (nth(B_DONE, 1030, 0) != d) begin bad++; $display("FAIL duty_done_idx: got %0d want %0d", nth(B_DONE, 1030, 0), d); end
        total++; if (tr[d][B_BUSY] !== 1'b1 || tr[d + 1][B_BUSY] !== 1'b0) begin bad++; $display("FAIL duty_busy_fall: got %b%b want 10", tr[d][B_BUSY], tr[d + 1][B_BUSY]); end
    endtask

    task automatic test_zero_window();
        clear_stim();
        in_start[0] = 1;
        for (int i = 0; i < 25; i++) in_comp[i] = 1;
        run(25);
        total++; if (cnt(B_WIN, 25) != 0 || cnt(B_EN, 25) != 0) begin bad++; $display("FAIL zero_no_window: got win %0d en %0d want 0 0", cnt(B_WIN, 25), cnt(B_EN, 25)); end
        total++; if (nth(B_DONE, 25, 0) != S + 1) begin bad++; $display("FAIL zero_done_idx: got %0d want %0d", nth(B_DONE, 25, 0), S + 1); end
        total++; if (cnt(B_BUSY, 25) != S + 1) begin bad++; $display("FAIL zero_busy_len: got %0d want %0d", cnt(B_BUSY, 25), S + 1); end
    endtask

    task automatic test_abort();
        int a;
        a = S + 40;
        clear_stim();
        in_start[0] = 1; in_abort[a] = 1; in_start[a + 1] = 1;
        for (int i = 0; i < 90; i++) begin in_comp[i] = 1; in_len[i] = (i <= a) ? 12'd100 : 12'd5; end
        run(90);
        total++; if (tr[a][B_WIN] !== 1'b1 || tr[a + 1][B_WIN] !== 1'b0) begin bad++; $display("FAIL abort_win_drop: got %b%b want 10", tr[a][B_WIN], tr[a + 1][B_WIN]); end
        total++; if (tr[a + 1][B_BUSY] !== 1'b0) begin bad++; $display("FAIL abort_idle: got busy %b want 0", tr[a + 1][B_BUSY]); end
        total++; if (tr[a + 2][B_CLR] !== 1'b1) begin bad++; $display("FAIL abort_restart_clear: got %b want 1", tr[a + 2][B_CLR]); end
        total++; if (cnt(B_DONE, 90) != 1 || nth(B_DONE, 90, 0) != a + 1 + S + 6) begin bad++; $display("FAIL abort_done: got n %0d idx %0d want n 1 idx %0d", cnt(B_DONE, 90), nth(B_DONE, 90, 0), a + 1 + S + 6); end
        total++; if (cnt(B_WIN, 90) != 45) begin bad++; $display("FAIL abort_win_total: got %0d want 45", cnt(B_WIN, 90)); end
    endtask

    task automatic test_continuous();
        int p;
        p = 1 + S + 10;
        clear_stim();
        in_start[0] = 1; in_start[40] = 1;
        for (int i = 0; i < 100; i++) begin in_comp[i] = 1; in_len[i] = 12'd10; in_cont[i] = (i < 3 * p); end
        run(100);
        total++; if (cnt(B_DONE, 100) != 3 || cnt(B_CLR, 100) != 3) begin bad++; $display("FAIL cont_counts: got done %0d clr %0d want 3 3", cnt(B_DONE, 100), cnt(B_CLR, 100)); end
        for (int k = 0; k < 3; k++) begin
            total++; if (nth(B_DONE, 100, k) != p * (k + 1)) begin bad++; $display("FAIL cont_done_%0d: got %0d want %0d", k, nth(B_DONE, 100, k), p * (k + 1)); end
            total++; if (nth(B_CLR, 100, k) != p * k + 1) begin bad++; $display("FAIL cont_clear_%0d: got %0d want %0d", k, nth(B_CLR, 100, k), p * k + 1); end
        end
        total++; if (tr[3 * p + 1][B_BUSY] !== 1'b0) begin bad++; $display("FAIL cont_stop: got busy %b want 0", tr[3 * p + 1][B_BUSY]); end
    endtask

    task automatic test_glitch();
        int want;
`ifdef COMP_FILTER_EN
        want = 0;
`else
        want = 1;
`endif
        clear_stim();
        in_start[0] = 1; in_comp[30] = 1;
        for (int i = 0; i < 130; i++) in_len[i] = 12'd100;
        run(130);
        total++; if (cnt(B_EN, 130) != want) begin bad++; $display("FAIL glitch_en_count: got %0d want %0d", cnt(B_EN, 130), want); end
        if (want == 1) begin
            total++; if (nth(B_EN, 130, 0) != 30 + SYNC) begin bad++; $display("FAIL glitch_latency: got %0d want %0d", nth(B_EN, 130, 0), 30 + SYNC); end
        end
    endtask

    task automatic test_reset_mid();
        clear_stim();
        in_start[0] = 1;
        for (int i = 0; i < 40; i++) begin in_comp[i] = 1; in_len[i] = 12'd100; end
        run(40);
        #2;
        total++; if (win_o !== 1'b1) begin bad++; $display("FAIL rstmid_pre_window: got %b want 1", win_o); end
        rst_n = 1'b0; start = 1'b1;
        #1;
        total++; if ({clr_o, win_o, en_o, busy_o, done_o} !== 5'b0) begin bad++; $display("FAIL rstmid_async: got %b want 00000", {clr_o, win_o, en_o, busy_o, done_o}); end
        repeat (3) @(negedge clk);
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rstmid_start_in_reset: got busy %b want 0", busy_o); end
        rst_n = 1'b1; start = 1'b0; comp = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin bad++; $display("FAIL rstmid_after: got busy %b done %b want 0 0", busy_o, done_o); end
    endtask

    function automatic bit hist(input int j);
        return (j < 0) ? 1'b0 : chist[j];
    endfunction

    function automatic bit comp_seen(input int k);
`ifdef COMP_FILTER_EN
        int v;
        v = int'(hist(k - 1 - SYNC)) + int'(hist(k - 2 - SYNC)) + int'(hist(k - 3 - SYNC));
        return v >= 2;
`else
        return hist(k - SYNC);
`endif
    endfunction

    // Reference: an accepted run at cycle s with length L produces clear at
    // s+1, window s+S+1..s+S+L, done at s+S+L+1 and busy from s+1 to done.
    task automatic test_random();
        bit act, e_clr, e_win, e_en, e_busy, e_done, cont_r;
        int s, L, off;
        clear_stim();
        run(6);
        act = 0; s = 0; L = 0; cont_r = 0;
        for (int k = 0; k < NRAND; k++) begin
            @(negedge clk);
            off    = k - s;
            e_clr  = act && off == 1;
            e_win  = act && off >= S + 1 && off <= S + L;
            e_done = act && off == S + L + 1;
            e_busy = act && off >= 1 && off <= S + L + 1;
            e_en   = e_win && comp_seen(k);
            total++; if (clr_o !== e_clr) begin bad++; $display("FAIL rand_clear c%0d: got %b want %b", k, clr_o, e_clr); end
            total++; if (win_o !== e_win) begin bad++; $display("FAIL rand_window c%0d: got %b want %b", k, win_o, e_win); end
            total++; if (en_o !== e_en) begin bad++; $display("FAIL rand_meas_en c%0d: got %b want %b", k, en_o, e_en); end
            total++; if (busy_o !== e_busy) begin bad++; $display("FAIL rand_busy c%0d: got %b want %b", k, busy_o, e_busy); end
            total++; if (done_o !== e_done) begin bad++; $display("FAIL rand_done c%0d: got %b want %b", k, done_o, e_done); end
            if ($urandom_range(0, 19) == 0) cont_r = ~cont_r;
            start = ($urandom_range(0, 5) == 0);
            abort = ($urandom_range(0, 59) == 0);
            cont  = cont_r;
            wlen  = ($urandom_range(0, 9) == 0) ? 12'd0 : 12'($urandom_range(1, 30));
            comp  = 1'($urandom_range(0, 1));
            chist[k] = comp;
            if (!act) begin
                if (start && !abort) begin act = 1; s = k; L = int'(wlen); end
            end else if (abort) begin
                act = 0;
            end else if (e_done) begin
                if (cont) begin s = k; L = int'(wlen); end
                else act = 0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_duty();
        test_zero_window();
        test_abort();
        test_continuous();
        test_glitch();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
